// File: rtl/rptr_empty_prefetch.sv
// Read-side FIFO control: Gray read pointer, empty/almost-empty flags, level,
// and a one-word registered output stage fed from an asynchronous-read memory.
module rptr_empty_prefetch #(
    parameter int unsigned ADDRSIZE      = 4,
    parameter int unsigned DATASIZE      = 8,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rmem_data,
    input  logic                rready,
    output logic                rvalid,
    output logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam logic [ADDRSIZE:0] AEMPTY_LVL = (ADDRSIZE + 1)'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wsync;
    logic [ADDRSIZE:0] level_next;
    logic              rinc;

    // Pop whenever the output register is free or being drained this cycle.
    always_comb begin
        rinc       = ~rempty & (~rvalid | rready);
        rbinnext   = rbin + (ADDRSIZE + 1)'(rinc);
        rgraynext  = (rbinnext >> 1) ^ rbinnext;
        wsync      = '0;
        for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
            wsync[i] = ^(rq2_wptr >> i);
        end
        level_next = wsync - rbinnext;
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            rlevel  <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            rlevel  <= level_next;
            raempty <= (level_next <= AEMPTY_LVL);
            if (rinc) begin
                rdata  <= rmem_data;
                rvalid <= 1'b1;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rptr_empty_prefetch.sv
// Directed bench for rptr_empty_prefetch with ADDRSIZE=2, DATASIZE=8, AEMPTY_THRESH=1.
module tb_rptr_empty_prefetch;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [2:0] rq2_wptr;
    logic [7:0] rmem_data;
    logic       rready;
    logic       rvalid;
    logic [7:0] rdata;
    logic [1:0] raddr;
    logic [2:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [2:0] rlevel;

    logic [7:0] mem [4];

    int passed = 0;
    int total  = 0;

    always #5 rclk = ~rclk;

    assign rmem_data = mem[raddr];

    rptr_empty_prefetch #(
        .ADDRSIZE      (2),
        .DATASIZE      (8),
        .AEMPTY_THRESH (1)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rq2_wptr  (rq2_wptr),
        .rmem_data (rmem_data),
        .rready    (rready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .raempty   (raempty),
        .rlevel    (rlevel)
    );

    typedef struct {
        logic       rst_n;
        logic [2:0] wptr;
        logic       rdy;
        logic       vld;
        logic [7:0] dat;
        logic       emp;
        logic       aemp;
        logic [2:0] lvl;
        logic [1:0] adr;
        logic [2:0] ptr;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [2:0] g2b(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [2:0] b2g(input logic [2:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic load_mem();
        mem[0] = 8'hA1;
        mem[1] = 8'hB2;
        mem[2] = 8'hC3;
        mem[3] = 8'hD4;
    endtask

    initial begin
        logic [2:0] wbin;
        logic [2:0] room;
        logic [7:0] exp_dat;
        int         nwr;
        int         nrd;
        int         cyc;

        vecs[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 2'd0, 3'b000};
        vecs[1]  = '{1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 2'd0, 3'b000};
        vecs[2]  = '{1'b1, 3'b010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 2'd0, 3'b000};
        vecs[3]  = '{1'b1, 3'b010, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 3'd2, 2'd1, 3'b001};
        vecs[4]  = '{1'b1, 3'b010, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 3'd2, 2'd1, 3'b001};
        vecs[5]  = '{1'b1, 3'b010, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 3'd1, 2'd2, 3'b011};
        vecs[6]  = '{1'b1, 3'b010, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 3'd0, 2'd3, 3'b010};
        vecs[7]  = '{1'b1, 3'b010, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 3'd0, 2'd3, 3'b010};
        vecs[8]  = '{1'b1, 3'b010, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 3'd0, 2'd3, 3'b010};
        vecs[9]  = '{1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 2'd0, 3'b000};
        vecs[10] = '{1'b1, 3'b110, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 2'd0, 3'b000};
        vecs[11] = '{1'b1, 3'b110, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 3'd3, 2'd1, 3'b001};
        vecs[12] = '{1'b1, 3'b110, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 3'd2, 2'd2, 3'b011};
        vecs[13] = '{1'b1, 3'b110, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 3'd1, 2'd3, 3'b010};
        vecs[14] = '{1'b1, 3'b110, 1'b1, 1'b1, 8'hD4, 1'b1, 1'b1, 3'd0, 2'd0, 3'b110};
        vecs[15] = '{1'b1, 3'b110, 1'b1, 1'b0, 8'hD4, 1'b1, 1'b1, 3'd0, 2'd0, 3'b110};

        load_mem();
        rrst_n   = 1'b0;
        rq2_wptr = 3'b000;
        rready   = 1'b0;

        // Table: reset, partial fill with stall, drain, full memory.
        for (int i = 0; i < 16; i++) begin
            rrst_n   = vecs[i].rst_n;
            rq2_wptr = vecs[i].wptr;
            rready   = vecs[i].rdy;
            @(posedge rclk);
            #1;
            check($sformatf("v%0d.rvalid", i),  32'(rvalid),  32'(vecs[i].vld));
            check($sformatf("v%0d.rdata", i),   32'(rdata),   32'(vecs[i].dat));
            check($sformatf("v%0d.rempty", i),  32'(rempty),  32'(vecs[i].emp));
            check($sformatf("v%0d.raempty", i), 32'(raempty), 32'(vecs[i].aemp));
            check($sformatf("v%0d.rlevel", i),  32'(rlevel),  32'(vecs[i].lvl));
            check($sformatf("v%0d.raddr", i),   32'(raddr),   32'(vecs[i].adr));
            check($sformatf("v%0d.rptr", i),    32'(rptr),    32'(vecs[i].ptr));
        end

        // Stream 20 words through a 4-deep memory with random rready; rbin wraps twice.
        rrst_n   = 1'b0;
        rready   = 1'b0;
        rq2_wptr = 3'b000;
        wbin     = 3'd0;
        nwr      = 0;
        nrd      = 0;
        @(posedge rclk);
        #1;
        rrst_n = 1'b1;
        cyc    = 0;
        while (nrd < 20 && cyc < 400) begin
            rready = 1'($urandom_range(0, 1));
            if (rvalid && rready) begin
                exp_dat = 8'h40 + 8'(nrd + 1);
                check($sformatf("stream.word%0d", nrd), 32'(rdata), 32'(exp_dat));
                nrd++;
            end
            room = wbin - g2b(rptr);
            if (nwr < 20 && room < 3'd4) begin
                mem[wbin[1:0]] = 8'h40 + 8'(nwr + 1);
                wbin           = wbin + 3'd1;
                rq2_wptr       = b2g(wbin);
                nwr++;
            end
            @(posedge rclk);
            #1;
            cyc++;
        end
        rready = 1'b0;
        check("stream.count", 32'(nrd), 32'd20);

        // Asynchronous reset while a word sits in the output register.
        load_mem();
        rrst_n   = 1'b0;
        rq2_wptr = 3'b000;
        @(posedge rclk);
        #1;
        rrst_n   = 1'b1;
        rq2_wptr = 3'b010;
        repeat (3) @(posedge rclk);
        #1;
        check("areset.pre_rvalid", 32'(rvalid), 32'd1);
        #2;
        rrst_n = 1'b0;
        #1;
        check("areset.rvalid", 32'(rvalid), 32'd0);
        check("areset.rempty", 32'(rempty), 32'd1);
        check("areset.rptr",   32'(rptr),   32'd0);
        check("areset.rlevel", 32'(rlevel), 32'd0);
        #2;
        rrst_n = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        check("resume.rdata", 32'(rdata),  32'hA1);
        check("resume.raddr", 32'(raddr),  32'd1);
        check("resume.rlevel", 32'(rlevel), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
